// File: rtl/ariane_emc_flash_rd_if.sv
// ariane_emc_flash_rd_if
// Request/response channel between the EMC APB bridge and the flash read engine.
//   req_valid / req_ready : request handshake, one halfword read per accept
//   req_addr  [26:0]      : byte address, bit 0 ignored by the engine
//   rsp_valid             : one-cycle pulse, rsp_data is valid
//   rsp_data  [15:0]      : captured halfword
// Modports: master = bridge side, slave = flash read engine.
interface ariane_emc_flash_rd_if;
    logic        req_valid;
    logic        req_ready;
    logic [26:0] req_addr;
    logic        rsp_valid;
    logic [15:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/ariane_emc_flash_rd.sv
// ariane_emc_flash_rd
// Asynchronous-mode parallel NOR (BPI) flash read engine. Accepts one 16-bit
// halfword read at a time from the EMC bridge, sequences CE#/OE# with
// programmed setup/access/recovery timing and returns the captured halfword.
// Read-only: WE# is tied inactive and the data bus is always an input.
//
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   bus (slave)       : req_valid/req_ready/req_addr, rsp_valid/rsp_data
//   flash_dq_i/o/t    : flash data bus (o tied 0, t tied all-1 = input)
//   flash_a           : flash address, bit 0 always 0
//   flash_we_b        : tied 1
//   flash_oe_b        : output enable, active low
//   flash_ce_b        : chip enable, active low
//   flash_adv_b       : tied 0 (asynchronous mode)
//   flash_wait        : flash WAIT, active high = data not ready
//
// Build option: EMC_FLASH_WAIT_EN
//   defined   : flash_wait is synchronized (2 flops) and extends ACCESS until
//               the counter has expired and the synced wait is low
//   undefined : flash_wait is ignored, timing is purely counter based
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | CE#=OE#=1, req_ready high, waiting for a request
// SETUP   | CE#=0, OE#=1 for SETUP_CYC cycles (address setup to OE#)
// ACCESS  | CE#=OE#=0 for ACC_CYC cycles, data sampled on the last edge
// RECOVER | CE#=OE#=1 for REC_CYC cycles, rsp_valid in the first cycle
module ariane_emc_flash_rd #(
    parameter int SETUP_CYC = 1,
    parameter int ACC_CYC   = 10,
    parameter int REC_CYC   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    ariane_emc_flash_rd_if.slave         bus,
    input  logic [15:0]                  flash_dq_i,
    output logic [15:0]                  flash_dq_o,
    output logic [15:0]                  flash_dq_t,
    output logic [26:0]                  flash_a,
    output logic                         flash_we_b,
    output logic                         flash_oe_b,
    output logic                         flash_ce_b,
    output logic                         flash_adv_b,
    input  logic                         flash_wait
);

    localparam int MAX_SA  = (SETUP_CYC > ACC_CYC) ? SETUP_CYC : ACC_CYC;
    localparam int MAX_CYC = (MAX_SA > REC_CYC) ? MAX_SA : REC_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] ACC_LD   = CNT_W'(ACC_CYC);
    localparam logic [CNT_W-1:0] REC_LD   = CNT_W'(REC_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               ce_b_q;
    logic               oe_b_q;
    logic               rsp_valid_q;
    logic [15:0]        rsp_data_q;
    logic [26:0]        addr_q;
    logic               wait_ok;

`ifdef EMC_FLASH_WAIT_EN
    logic wait_s1;
    logic wait_s2;
    logic unused_addr0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_s1 <= 1'b0;
            wait_s2 <= 1'b0;
        end else begin
            wait_s1 <= flash_wait;
            wait_s2 <= wait_s1;
        end
    end

    assign wait_ok      = !wait_s2;
    assign unused_addr0 = bus.req_addr[0];
`else
    logic unused_in;

    assign wait_ok   = 1'b1;
    assign unused_in = flash_wait ^ bus.req_addr[0];
`endif

    // Combinational ready, forced low during reset so a request held across
    // reset is not taken on the reset edge.
    assign bus.req_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ce_b_q      <= 1'b1;
            oe_b_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            addr_q      <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q <= {bus.req_addr[26:1], 1'b0};
                        cnt    <= SETUP_LD;
                        ce_b_q <= 1'b0;
                        oe_b_q <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == CNT_ONE) begin
                        cnt    <= ACC_LD;
                        oe_b_q <= 1'b0;
                        state  <= ACCESS;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ACCESS: begin
                    // Counter parks at 1 while WAIT holds the access open.
                    if (cnt == CNT_ONE) begin
                        if (wait_ok) begin
                            rsp_data_q  <= flash_dq_i;
                            rsp_valid_q <= 1'b1;
                            ce_b_q      <= 1'b1;
                            oe_b_q      <= 1'b1;
                            cnt         <= REC_LD;
                            state       <= RECOVER;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                RECOVER: begin
                    if (cnt == CNT_ONE) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign flash_a       = addr_q;
    assign flash_ce_b    = ce_b_q;
    assign flash_oe_b    = oe_b_q;
    assign flash_we_b    = 1'b1;
    assign flash_adv_b   = 1'b0;
    assign flash_dq_o    = '0;
    assign flash_dq_t    = '1;

endmodule
